ffd: RTL and testbench

FFD -- requirements
Module: ffd

---
 rtl/ffd.sv | 60 ++++++
 tb/tb_ffd.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ffd.sv
// ffd: parameterised register pipeline (STAGES x WIDTH) with synchronous reset.
//
// Parameters
//   WIDTH       : data width of d and q, 1..64
//   STAGES      : number of cascaded register stages, 1..8
//   RESET_VALUE : value loaded into every stage while reset is asserted
//
// Ports
//   aclk  : clock, all state changes on its rising edge
//   arstn : synchronous reset, active-high (name kept for compatibility only)
//   d     : data input
//   q     : data output, taken straight from the last stage register
module ffd #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject out-of-range parameters at elaboration time.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("ffd: WIDTH=%0d is outside the legal range 1..64", WIDTH);
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("ffd: STAGES=%0d is outside the legal range 1..8", STAGES);
    end

    // One register per stage; each lives in its own generate scope so every
    // variable has exactly one driver.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] r;

        if (k == 0) begin : g_first
            // First stage captures d; reset wins over capture.
            always_ff @(posedge aclk) begin
                if (arstn) begin
                    r <= RESET_VALUE;
                end else begin
                    r <= d;
                end
            end
        end else begin : g_next
            // Later stages shift the previous stage forward.
            always_ff @(posedge aclk) begin
                if (arstn) begin
                    r <= RESET_VALUE;
                end else begin
                    r <= g_stage[k-1].r;
                end
            end
        end
    end

    assign q = g_stage[STAGES-1].r;

endmodule

// File: tb/tb_ffd.sv
// tb_ffd: self-checking bench for ffd. Four instances with different
// parameters share one clock; a per-instance queue holds the values expected
// to emerge on q on successive edges.
module tb_ffd;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // u0: defaults; u1: 8-bit, 3 stages; u2: 1-bit, reset value 1;
    // u3: 8-bit, 2 stages, reset value 8'h3C.
    localparam logic [7:0] RV0 = 8'h00;
    localparam logic [7:0] RV1 = 8'h00;
    localparam logic [7:0] RV2 = 8'h01;
    localparam logic [7:0] RV3 = 8'h3C;

    logic       r0, r1, r2, r3;
    logic [0:0] d0, d2;
    logic [7:0] d1, d3;
    logic [0:0] q0, q2;
    logic [7:0] q1, q3;

    ffd u0 (.aclk(aclk), .arstn(r0), .d(d0), .q(q0));
    ffd #(.WIDTH(8), .STAGES(3)) u1 (.aclk(aclk), .arstn(r1), .d(d1), .q(q1));
    ffd #(.RESET_VALUE(1'b1)) u2 (.aclk(aclk), .arstn(r2), .d(d2), .q(q2));
    ffd #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'h3C)) u3 (.aclk(aclk), .arstn(r3), .d(d3), .q(q3));

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    logic [7:0] sb2[$];
    logic [7:0] sb3[$];
    logic [7:0] last0, last1, last2, last3;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load the scoreboard for one instance from the stimulus about to be sampled.
    task automatic sb_push(input int idx, input logic rst, input logic [7:0] dv,
                           input int stages, input logic [7:0] rv);
        if (rst) begin
            case (idx)
                0: sb0.delete();
                1: sb1.delete();
                2: sb2.delete();
                default: sb3.delete();
            endcase
            for (int i = 0; i < stages; i++) begin
                case (idx)
                    0: sb0.push_back(rv);
                    1: sb1.push_back(rv);
                    2: sb2.push_back(rv);
                    default: sb3.push_back(rv);
                endcase
            end
        end else begin
            case (idx)
                0: sb0.push_back(dv);
                1: sb1.push_back(dv);
                2: sb2.push_back(dv);
                default: sb3.push_back(dv);
            endcase
        end
    endtask

    // Record current stimulus, take one edge, then compare every output.
    task automatic step();
        sb_push(0, r0, {7'd0, d0}, 1, RV0);
        sb_push(1, r1, d1, 3, RV1);
        sb_push(2, r2, {7'd0, d2}, 1, RV2);
        sb_push(3, r3, d3, 2, RV3);
        @(posedge aclk);
        #1;
        last0 = sb0.pop_front();
        last1 = sb1.pop_front();
        last2 = sb2.pop_front();
        last3 = sb3.pop_front();
        check("u0_q", {7'd0, q0}, last0);
        check("u1_q", q1, last1);
        check("u2_q", {7'd0, q2}, last2);
        check("u3_q", q3, last3);
    endtask

    task automatic set_all(input logic rst, input logic [7:0] dv);
        r0 = rst; r1 = rst; r2 = rst; r3 = rst;
        d0 = dv[0]; d1 = dv; d2 = dv[0]; d3 = dv;
    endtask

    initial begin
        set_all(1'b0, 8'h00);
        #1;

        // Reset held for 25 edges with d = 0, then d = all ones under reset.
        set_all(1'b1, 8'h00);
        repeat (25) step();
        set_all(1'b1, 8'hFF);
        repeat (3) step();

        // Release reset with d = 0; reset values must persist for STAGES edges.
        set_all(1'b0, 8'h00);
        step();

        // u0 toggle 0,1,1,0; u1 single A5 pulse; u2 falls to 0 one edge after release.
        d0 = 1'b0; d1 = 8'hA5; step();
        d0 = 1'b1; d1 = 8'h00; step();
        d0 = 1'b1; step();
        d0 = 1'b0; step();
        repeat (4) step();

        // Mid-stream one-edge reset pulse on u3 and u0.
        for (int i = 0; i < 12; i++) begin
            d0 = 1'($urandom); d1 = 8'($urandom); d2 = 1'($urandom); d3 = 8'($urandom);
            r3 = (i == 6);
            r0 = (i == 8);
            step();
        end
        r0 = 1'b0; r3 = 1'b0;
        repeat (4) step();

        // Glitch on d between edges must not reach q.
        d0 = 1'b0; d1 = 8'h00; d2 = 1'b0; d3 = 8'h00;
        step();
        d0 = 1'b1; d1 = 8'hFF; d2 = 1'b1; d3 = 8'hFF;
        #2;
        check("glitch_u0", {7'd0, q0}, last0);
        check("glitch_u3", q3, last3);
        d0 = 1'b0; d1 = 8'h00; d2 = 1'b0; d3 = 8'h00;
        repeat (4) step();

        // Reset asserted between edges must not change q before the edge.
        d0 = 1'b1; d1 = 8'h5A; d2 = 1'b1; d3 = 8'h99;
        repeat (3) step();
        set_all(1'b1, 8'h77);
        #2;
        check("rst_mid_u0", {7'd0, q0}, last0);
        check("rst_mid_u1", q1, last1);
        check("rst_mid_u2", {7'd0, q2}, last2);
        check("rst_mid_u3", q3, last3);
        step();
        set_all(1'b0, 8'h00);

        // Random stream with sparse random resets per instance.
        for (int i = 0; i < 200; i++) begin
            d0 = 1'($urandom); d1 = 8'($urandom); d2 = 1'($urandom); d3 = 8'($urandom);
            r0 = ($urandom_range(15) == 0);
            r1 = ($urandom_range(15) == 0);
            r2 = ($urandom_range(15) == 0);
            r3 = ($urandom_range(15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
